// File: rtl/versat_databus_arbiter_pkg.sv
// Shared types and helpers for the Versat databus arbiter.
//   state_e      : arbiter FSM state (IDLE=0, BUSY=1)
//   calc_grant_w : width of a requester index, max(1, clog2(n_req))
package versat_databus_arbiter_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StBusy = 1'b1
    } state_e;

    function automatic int unsigned calc_grant_w(int unsigned n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/versat_databus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set bit of req, searching upward from prio with wrap-around.
//   req   : request vector, one bit per requester
//   prio  : index where the search starts (must be < N_REQ)
//   found : at least one request bit is set
//   idx   : index of the selected requester (0 when nothing is found)
module rr_pick
    import versat_databus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned GRANT_W = calc_grant_w(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] prio,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    int unsigned        cand_int;
    logic [GRANT_W-1:0] cand;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand_int = 0;
        cand     = '0;
        // Walk offsets 0..N_REQ-1 from prio; the first hit wins.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand_int = (32'(prio) + i) % N_REQ;
            cand     = GRANT_W'(cand_int);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/versat_databus_arbiter.sv
// Round-robin arbiter sharing one memory-side databus between N_REQ Versat units.
// A granted requester keeps the bus until the memory side returns its final beat.
//   clk, rst                   : clock, asynchronous active-high reset
//   req_valid/addr/wdata/
//   req_wstrb/len              : flattened per-requester requests (requester k at [k*W +: W])
//   req_ready, req_last        : per-requester handshake, only the owner ever sees them high
//   req_rdata                  : read data broadcast to every requester
//   m_valid/addr/wdata/
//   m_wstrb/len                : memory-side request, muxed from the owner while BUSY
//   m_ready, m_rdata, m_last   : memory-side response
//   busy                       : arbiter is in BUSY
//   grant_id                   : index of the current owner
module versat_databus_arbiter
    import versat_databus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8,
    localparam int unsigned STRB_W  = DATA_W / 8,
    localparam int unsigned GRANT_W = calc_grant_w(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [N_REQ*STRB_W-1:0]   req_wstrb,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          req_last,
    output logic [DATA_W-1:0]         req_rdata,

    output logic                      m_valid,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [STRB_W-1:0]         m_wstrb,
    output logic [LEN_W-1:0]          m_len,
    input  logic                      m_ready,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_last,

    output logic                      busy,
    output logic [GRANT_W-1:0]        grant_id
);

    state_e             state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] prio_q, prio_d;

    logic               pick_found;
    logic [GRANT_W-1:0] pick_idx;
    logic               txn_end;

    rr_pick #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req   (req_valid),
        .prio  (prio_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Final beat accepted by the memory side.
    assign txn_end = (state_q == StBusy) && m_valid && m_ready && m_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                // Lock holds until the last beat, even if the owner drops valid.
                if (txn_end) begin
                    state_d = StIdle;
                    prio_d  = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Unregistered mux from the owner onto the memory side.
    always_comb begin
        m_valid   = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_len     = '0;
        req_ready = '0;
        req_last  = '0;
        if (state_q == StBusy) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (grant_q == GRANT_W'(k)) begin
                    m_valid      = req_valid[k];
                    m_addr       = req_addr[k*ADDR_W +: ADDR_W];
                    m_wdata      = req_wdata[k*DATA_W +: DATA_W];
                    m_wstrb      = req_wstrb[k*STRB_W +: STRB_W];
                    m_len        = req_len[k*LEN_W +: LEN_W];
                    req_ready[k] = m_ready;
                    req_last[k]  = m_last;
                end
            end
        end
    end

    assign req_rdata = m_rdata;
    assign busy      = (state_q == StBusy);
    assign grant_id  = grant_q;

endmodule
